muldiv_sequencer: RTL and testbench

- Multi-cycle HI/LO unit serving the decoded MULT/MULTU/DIV/DIVU/MTHI/MTLO instructions.
- Sits in the execute stage beside the ALU and owns the architectural HI and LO registers.
- Runs a shift-add multiplier and a restoring divider on operand magnitudes, one bit per cycle, with a sign-fixup cycle at the end.
- Raises busy so the pipeline stalls any HI/LO consumer. Accepts a cancel from exception flush.

---
 rtl/muldiv_sequencer.sv | 149 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: HI/LO unit for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
// Multiplies by shift-add and divides by restoring subtraction on operand
// magnitudes, one bit per cycle, then applies the signs in a FIXUP cycle.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            cancel,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIXUP} state_t;

  state_t state_reg, state_next;

  // acc_reg is shared: MUL holds {partial product, remaining multiplier},
  // DIV holds {partial remainder, dividend shifting into quotient}.
  logic [2*XLEN-1:0] acc_reg;
  logic [XLEN-1:0]   opnd_reg;   // multiplicand (MUL) or divisor (DIV) magnitude
  logic [XLEN-1:0]   a_raw_reg;  // raw dividend, reported in HI on divide by zero
  logic [XLEN-1:0]   hi_reg, lo_reg;
  logic [CW-1:0]     cnt_reg;
  logic              is_div_reg, div0_reg, sign_q_reg, sign_r_reg, done_reg;

  logic              launch, last_iter, in_idle, in_fixup;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] mul_step, div_step, product;
  logic [XLEN-1:0]   quot_fix, rem_fix;

  assign in_idle   = (state_reg == IDLE);
  assign in_fixup  = (state_reg == FIXUP);
  assign launch    = in_idle & start & ~cancel;
  assign last_iter = (cnt_reg == CW'(XLEN-1));

  // Signed ops work on magnitudes; op[0]=1 means unsigned.
  assign a_mag = (a[XLEN-1] & ~op[0]) ? -a : a;
  assign b_mag = (b[XLEN-1] & ~op[0]) ? -b : b;

  // Shift-add: add multiplicand to the upper half if the current multiplier
  // bit is set, then shift the whole accumulator right by one.
  assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]}
                  + ({1'b0, opnd_reg} & {(XLEN+1){acc_reg[0]}});
  assign mul_step = {mul_sum, acc_reg[XLEN-1:1]};

  // Restoring divide: shift the next dividend bit into the remainder, try
  // the subtraction, keep it and record a 1 only if it did not go negative.
  assign div_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_reg};
  assign div_step  = div_diff[XLEN]
                   ? {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0}
                   : {div_diff[XLEN-1:0],  acc_reg[XLEN-2:0], 1'b1};

  assign product  = sign_q_reg ? -acc_reg : acc_reg;
  assign quot_fix = sign_q_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
  assign rem_fix  = sign_r_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Next-state logic: iterate XLEN cycles, one FIXUP cycle, cancel aborts.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start && !cancel) state_next = op[1] ? DIV : MUL;
      MUL,
      DIV:     if (cancel)         state_next = IDLE;
               else if (last_iter) state_next = FIXUP;
      FIXUP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand latch at launch and one iteration step per cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc_reg    <= '0;
      opnd_reg   <= '0;
      a_raw_reg  <= '0;
      cnt_reg    <= '0;
      is_div_reg <= 1'b0;
      div0_reg   <= 1'b0;
      sign_q_reg <= 1'b0;
      sign_r_reg <= 1'b0;
    end else if (launch) begin
      acc_reg    <= {{XLEN{1'b0}}, (op[1] ? a_mag : b_mag)};
      opnd_reg   <= op[1] ? b_mag : a_mag;
      a_raw_reg  <= a;
      cnt_reg    <= '0;
      is_div_reg <= op[1];
      div0_reg   <= (b == '0);
      sign_q_reg <= ~op[0] & (a[XLEN-1] ^ b[XLEN-1]);
      sign_r_reg <= ~op[0] & a[XLEN-1];
    end else if (state_reg == MUL) begin
      acc_reg <= mul_step;
      cnt_reg <= cnt_reg + 1'b1;
    end else if (state_reg == DIV) begin
      acc_reg <= div_step;
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // HI/LO: result write on FIXUP exit, otherwise MTHI/MTLO when idle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi_reg   <= '0;
      lo_reg   <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= in_fixup & ~cancel;
      if (in_fixup && !cancel) begin
        if (!is_div_reg) begin
          {hi_reg, lo_reg} <= product;
        end else if (div0_reg) begin
          hi_reg <= a_raw_reg;
          lo_reg <= '1;
        end else begin
          hi_reg <= rem_fix;
          lo_reg <= quot_fix;
        end
      end else if (in_idle && !start) begin
        if (mthi) hi_reg <= wdata;
        if (mtlo) lo_reg <= wdata;
      end
    end
  end

  assign busy = ~in_idle;
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench for the HI/LO sequencer.
module tb_muldiv_sequencer;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      op = 2'b00;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic            cancel = 1'b0;
  logic            mthi = 1'b0;
  logic            mtlo = 1'b0;
  logic [XLEN-1:0] wdata = '0;
  logic            busy, done;
  logic [XLEN-1:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_res = '0;

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference {hi,lo} from plain language arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    logic signed [63:0] sx, sy, q, r;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    case (o)
      2'b00: return sx * sy;
      2'b01: return {32'b0, x} * {32'b0, y};
      2'b10: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Drive start for one cycle; returns #1 after the sampling edge (cycle T+1).
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit push, input bit with_mthi);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    if (with_mthi) begin
      mthi = 1'b1; wdata = 32'h0000_BEEF;
    end
    if (push) exp_q.push_back(model(o, x, y));
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0;
  endtask

  // Wait (bounded) for done, check latency, then pop and compare the result.
  task automatic wait_done(input string tag, input int exp_busy);
    int busy_cycles = 0;
    bit got = 0;
    logic [63:0] e;
    for (int i = 0; i < 40 && !got; i++) begin
      if (done) got = 1;
      else begin
        if (busy) busy_cycles++;
        @(posedge clk); #1;
      end
    end
    check($sformatf("%s done", tag), 64'(got), 64'd1);
    check($sformatf("%s busy_cycles", tag), 64'(busy_cycles), 64'(exp_busy));
    check($sformatf("%s busy_in_done", tag), 64'(busy), 64'd0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      last_res = e;
      check($sformatf("%s hi", tag), 64'(hi), 64'(e[63:32]));
      check($sformatf("%s lo", tag), 64'(lo), 64'(e[31:0]));
      $display("txn %s: op=%0d a=0x%08h b=0x%08h hi=0x%08h lo=0x%08h", tag, op, a, b, hi, lo);
    end
  endtask

  // Count done pulses over a window where none may appear.
  task automatic no_done(input string tag);
    int pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check(tag, 64'(pulses), 64'd0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);
    @(negedge clk); resetn = 1'b1;

    // MULT -2 * 3, exact latency
    launch(2'b00, 32'hFFFF_FFFE, 32'd3, 1, 0);
    wait_done("mult", XLEN + 1);

    // MULTU, then DIV -7/2 launched in the done cycle
    launch(2'b01, 32'hFFFF_FFFE, 32'd3, 1, 0);
    wait_done("multu", XLEN + 1);
    launch(2'b10, 32'hFFFF_FFF9, 32'd2, 1, 0);
    wait_done("div_b2b", XLEN + 1);

    // Divide by zero and signed overflow
    launch(2'b11, 32'd7, 32'd0, 1, 0);
    wait_done("divu_by0", XLEN + 1);
    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
    wait_done("div_ovf", XLEN + 1);

    // MTHI / MTLO in idle
    @(negedge clk); mthi = 1'b1; wdata = 32'h1234;
    @(negedge clk); mthi = 1'b0; mtlo = 1'b1; wdata = 32'h5678;
    @(negedge clk); mtlo = 1'b0;
    @(posedge clk); #1;
    check("mthi hi", 64'(hi), 64'h1234);
    check("mtlo lo", 64'(lo), 64'h5678);

    // DIVU 100/7 cancelled during cycle T+10
    launch(2'b11, 32'd100, 32'd7, 0, 0);
    repeat (9) @(posedge clk);
    @(negedge clk); cancel = 1'b1;
    @(posedge clk); #1; cancel = 1'b0;
    check("cancel busy", 64'(busy), 64'd0);
    check("cancel done", 64'(done), 64'd0);
    no_done("cancel no_done");
    check("cancel hi", 64'(hi), 64'h1234);
    check("cancel lo", 64'(lo), 64'h5678);

    // start together with cancel in IDLE is dropped
    @(negedge clk); start = 1'b1; cancel = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
    @(posedge clk); #1; start = 1'b0; cancel = 1'b0;
    check("start_cancel busy", 64'(busy), 64'd0);

    // MTLO while busy is ignored
    launch(2'b01, 32'h0001_0000, 32'h0003_0000, 1, 0);
    mtlo = 1'b1; wdata = 32'h0000_DEAD;
    @(posedge clk); #1; mtlo = 1'b0;
    wait_done("mtlo_busy", XLEN);

    // start + MTHI in the same cycle: move dropped, HI keeps old result until done
    launch(2'b00, 32'd6, 32'hFFFF_FFF9, 1, 1);
    check("start_mthi hi_hold", 64'(hi), 64'(last_res[63:32]));
    wait_done("start_mthi", XLEN + 1);

    // Random operations
    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : $urandom >> $urandom_range(0, 28);
      launch(ro, ra, rb, 1, 0);
      wait_done($sformatf("rand%0d", i), XLEN + 1);
    end

    // Reset during cycle T+20 of MULTU 5*6
    launch(2'b01, 32'd5, 32'd6, 0, 0);
    repeat (19) @(posedge clk);
    @(negedge clk); resetn = 1'b0;
    @(posedge clk); #1; resetn = 1'b1;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst hi", 64'(hi), 64'd0);
    check("midrst lo", 64'(lo), 64'd0);
    no_done("midrst no_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
